seven_seg_scan_decoder: RTL and testbench

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

---
 rtl/seven_seg_scan_decoder_pkg.sv | 25 ++
 rtl/seven_seg_scan_decoder_if.sv | 38 +++
 rtl/seven_seg_scan_decoder_seg_to_hex.sv | 20 ++
 rtl/seven_seg_scan_decoder.sv | 155 +++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared segment-code table and output FSM state type for the
// scanned seven-segment decoder and its companion hex encoder.
package seven_seg_scan_decoder_pkg;

  localparam int SEG_W = 7;

  // Entry i is the segment pattern for hex digit i (bit0=a .. bit6=g).
  localparam logic [15:0][SEG_W-1:0] SEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_t;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Scan-side inputs and frame-side handshake of the seven-segment
// scan decoder; the decoder attaches through the slave modport.
interface seven_seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);

  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    strobe;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic                    value_valid;
  logic                    value_ack;
  logic                    code_err;
  logic                    overflow;

  modport master (
    output seg_in,
    output digit_sel,
    output strobe,
    output value_ack,
    input  value_out,
    input  value_valid,
    input  code_err,
    input  overflow
  );

  modport slave (
    input  seg_in,
    input  digit_sel,
    input  strobe,
    input  value_ack,
    output value_out,
    output value_valid,
    output code_err,
    output overflow
  );

endinterface

// File: rtl/seven_seg_scan_decoder_seg_to_hex.sv
// Combinational segment-pattern to hex-nibble lookup; any pattern
// outside the 16-entry table comes back with valid cleared.
module seg_to_hex
  import seven_seg_scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output hex_t             hex
);

  always_comb begin
    hex = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODES[i]) begin
        hex.valid  = 1'b1;
        hex.nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Scanned seven-segment decoder: assembles per-digit nibbles into frames.
// Optional SEG_STABLE_FILTER_EN adds a per-digit code stability filter.
module seven_seg_scan_decoder
  import seven_seg_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input logic                     clk,
  input logic                     rst,
  seven_seg_scan_decoder_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || STABLE_CNT < 1) begin : g_cfg_chk
    $error("NUM_DIGITS and STABLE_CNT must be at least 1");
  end

  state_t                      state_q, state_d;
  logic [4*NUM_DIGITS-1:0]     value_q, value_d;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]       captured_q, captured_d;
  logic                        err_q, err_d;
  logic                        ovf_q, ovf_d;

  hex_t                        dec;
  logic                        sel_ok;
  logic [IW-1:0]               sel_idx;
  logic                        accept;
  logic                        done;

`ifdef SEG_STABLE_FILTER_EN
  localparam int CW = $clog2(STABLE_CNT + 1);
  logic [NUM_DIGITS-1:0][6:0]    last_q, last_d;
  logic [NUM_DIGITS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]                 cnt_nxt;
`endif

  seg_to_hex u_dec (
    .seg (bus.seg_in),
    .hex (dec)
  );

  assign sel_ok = $onehot(bus.digit_sel);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.digit_sel[i]) sel_idx = IW'(i);
    end
  end

  // Capture path: filter, shadow registers, captured flags
  always_comb begin
    err_d      = 1'b0;
    shadow_d   = shadow_q;
    captured_d = captured_q;
    accept     = 1'b0;
    done       = 1'b0;
`ifdef SEG_STABLE_FILTER_EN
    last_d     = last_q;
    cnt_d      = cnt_q;
    cnt_nxt    = '0;
`endif
    if (bus.strobe) begin
      if (!sel_ok) begin
        err_d = 1'b1;
      end else if (!dec.valid) begin
        err_d               = 1'b1;
        captured_d[sel_idx] = 1'b0;
`ifdef SEG_STABLE_FILTER_EN
        cnt_d[sel_idx]      = '0;
`endif
      end else begin
`ifdef SEG_STABLE_FILTER_EN
        if (last_q[sel_idx] == bus.seg_in && cnt_q[sel_idx] != '0) begin
          cnt_nxt = (cnt_q[sel_idx] == CW'(STABLE_CNT)) ?
                    cnt_q[sel_idx] : cnt_q[sel_idx] + 1'b1;
        end else begin
          cnt_nxt = CW'(1);
        end
        last_d[sel_idx] = bus.seg_in;
        cnt_d[sel_idx]  = cnt_nxt;
        accept          = (cnt_nxt >= CW'(STABLE_CNT));
`else
        accept = 1'b1;
`endif
      end
      if (accept) begin
        shadow_d[sel_idx]   = dec.nibble;
        captured_d[sel_idx] = 1'b1;
      end
      done = &captured_d;
      if (done) captured_d = '0;
    end
  end

  // Output FSM: frame hand-off and drop tracking
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (done) begin
          state_d = ST_HOLD;
          value_d = shadow_d;
        end
      end
      ST_HOLD: begin
        if (bus.value_ack) begin
          ovf_d = 1'b0;
          if (done) value_d = shadow_d;
          else      state_d = ST_IDLE;
        end else if (done) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      shadow_q   <= '0;
      captured_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef SEG_STABLE_FILTER_EN
      last_q     <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      shadow_q   <= shadow_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
`ifdef SEG_STABLE_FILTER_EN
      last_q     <= last_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.value_out   = value_q;
  assign bus.value_valid = (state_q == ST_HOLD);
  assign bus.code_err    = err_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomized and directed bench for seven_seg_scan_decoder against
// a frame-level reference model; honours SEG_STABLE_FILTER_EN.
module tb_seven_seg_scan_decoder;

  localparam int ND     = 4;
  localparam int STABLE = 3;

  logic clk;
  logic rst;

  seven_seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_decoder #(
    .NUM_DIGITS (ND),
    .STABLE_CNT (STABLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [6:0] codes [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model state
  int          m_sh  [ND];
  bit          m_cap [ND];
  int          f_last[ND];
  int          f_cnt [ND];
  logic [15:0] m_val;
  bit          m_vld;
  bit          m_ovf;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] seg);
    int k;
    k = -1;
    for (int i = 0; i < 16; i++) if (codes[i] == seg) k = i;
    return k;
  endfunction

  task automatic model(input bit r, input bit s, input logic [3:0] sel,
                       input logic [6:0] seg, input bit a);
    int          k;
    int          idx;
    bit          ok;
    bit          done;
    bit          all;
    logic [15:0] frame;
    if (r) begin
      for (int i = 0; i < ND; i++) begin
        m_sh[i] = 0; m_cap[i] = 0; f_last[i] = 0; f_cnt[i] = 0;
      end
      m_val = '0; m_vld = 0; m_ovf = 0; m_err = 0;
      return;
    end
    m_err = 0;
    done  = 0;
    frame = '0;
    if (s) begin
      if ($countones(sel) != 1) begin
        m_err = 1;
      end else begin
        idx = 0;
        for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
        k = lookup(seg);
        if (k < 0) begin
          m_err = 1; m_cap[idx] = 0; f_cnt[idx] = 0;
        end else begin
`ifdef SEG_STABLE_FILTER_EN
          if (f_cnt[idx] > 0 && f_last[idx] == int'(seg))
            f_cnt[idx] = (f_cnt[idx] < STABLE) ? f_cnt[idx] + 1 : STABLE;
          else
            f_cnt[idx] = 1;
          f_last[idx] = int'(seg);
          ok = (f_cnt[idx] >= STABLE);
`else
          ok = 1;
`endif
          if (ok) begin
            m_sh[idx] = k; m_cap[idx] = 1;
          end
        end
      end
      all = 1;
      for (int i = 0; i < ND; i++) if (!m_cap[i]) all = 0;
      if (all) begin
        done = 1;
        for (int i = 0; i < ND; i++) begin
          frame[4*i +: 4] = 4'(m_sh[i]);
          m_cap[i] = 0;
        end
      end
    end
    if (!m_vld) begin
      if (done) begin m_vld = 1; m_val = frame; end
    end else if (a) begin
      m_ovf = 0;
      if (done) m_val = frame;
      else      m_vld = 0;
    end else if (done) begin
      m_ovf = 1;
    end
  endtask

  task automatic tick(input bit r, input bit s, input logic [3:0] sel,
                      input logic [6:0] seg, input bit a);
    rst           = r;
    bus.strobe    = s;
    bus.digit_sel = sel;
    bus.seg_in    = seg;
    bus.value_ack = a;
    @(posedge clk);
    model(r, s, sel, seg, a);
    #1;
    chk("value_valid", 32'(bus.value_valid), 32'(m_vld));
    chk("value_out",   32'(bus.value_out),   32'(m_val));
    chk("code_err",    32'(bus.code_err),    32'(m_err));
    chk("overflow",    32'(bus.overflow),    32'(m_ovf));
  endtask

  // One logical digit delivery (repeated until the filter accepts it)
  task automatic put(input logic [3:0] sel, input logic [6:0] seg);
`ifdef SEG_STABLE_FILTER_EN
    for (int i = 0; i < STABLE; i++) tick(0, 1, sel, seg, 0);
`else
    tick(0, 1, sel, seg, 0);
`endif
  endtask

  task automatic idle(input bit a);
    tick(0, 0, 4'h0, 7'h00, a);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk   = 0;
    rst   = 1;
    bus.strobe = 0; bus.digit_sel = '0; bus.seg_in = '0; bus.value_ack = 0;

    tick(1, 0, 4'h0, 7'h00, 0);
    tick(1, 0, 4'h0, 7'h00, 0);
    chk("rst_valid", 32'(bus.value_valid), 32'd0);
    chk("rst_value", 32'(bus.value_out),   32'd0);
    chk("rst_ovf",   32'(bus.overflow),    32'd0);
    chk("rst_err",   32'(bus.code_err),    32'd0);

    // Basic frame and acknowledge
    put(4'b0001, 7'h3F); put(4'b0010, 7'h06);
    put(4'b0100, 7'h5B); put(4'b1000, 7'h4F);
    chk("frm_valid", 32'(bus.value_valid), 32'd1);
    chk("frm_value", 32'(bus.value_out),   32'h3210);
    idle(1);
    chk("ack_valid", 32'(bus.value_valid), 32'd0);
    chk("ack_keep",  32'(bus.value_out),   32'h3210);

    // Invalid code clears digit 0
    tick(0, 1, 4'b0001, 7'h00, 0);
    chk("bad_code_err", 32'(bus.code_err), 32'd1);
    idle(0);
    chk("err_pulse", 32'(bus.code_err), 32'd0);
    put(4'b0010, 7'h06); put(4'b0100, 7'h5B); put(4'b1000, 7'h4F);
    chk("no_frame_a", 32'(bus.value_valid), 32'd0);

    // Non-one-hot select is ignored
    tick(1, 0, 4'h0, 7'h00, 0);
    tick(0, 1, 4'b0011, 7'h3F, 0);
    chk("bad_sel_err", 32'(bus.code_err), 32'd1);
    put(4'b0010, 7'h06); put(4'b0100, 7'h5B); put(4'b1000, 7'h4F);
    chk("no_frame_b", 32'(bus.value_valid), 32'd0);

    // Dropped frame sets overflow; ack clears it
    tick(1, 0, 4'h0, 7'h00, 0);
    for (int i = 0; i < ND; i++) put(4'(1 << i), 7'h06);
    chk("f1_value", 32'(bus.value_out), 32'h1111);
    for (int i = 0; i < ND; i++) put(4'(1 << i), 7'h5B);
    chk("drop_value", 32'(bus.value_out), 32'h1111);
    chk("drop_ovf",   32'(bus.overflow),  32'd1);
    idle(1);
    chk("ovf_clear", 32'(bus.overflow),    32'd0);
    chk("ovf_idle",  32'(bus.value_valid), 32'd0);

    // Reset mid-frame discards partial digits
    put(4'b0001, 7'h3F); put(4'b0010, 7'h06);
    tick(1, 1, 4'b0100, 7'h5B, 1);
    chk("rst_prio", 32'(bus.value_valid), 32'd0);
    put(4'b0100, 7'h39); put(4'b1000, 7'h5E);
    chk("rst_partial", 32'(bus.value_valid), 32'd0);
    put(4'b0001, 7'h77); put(4'b0010, 7'h7C);
    chk("rst_frame", 32'(bus.value_out), 32'hDCBA);
    idle(1);

`ifdef SEG_STABLE_FILTER_EN
    // Stability filter on digit 0
    tick(1, 0, 4'h0, 7'h00, 0);
    put(4'b0010, 7'h06); put(4'b0100, 7'h5B); put(4'b1000, 7'h4F);
    tick(0, 1, 4'b0001, 7'h3F, 0);
    tick(0, 1, 4'b0001, 7'h3F, 0);
    tick(0, 1, 4'b0001, 7'h06, 0);
    tick(0, 1, 4'b0001, 7'h06, 0);
    chk("flt_wait", 32'(bus.value_valid), 32'd0);
    tick(0, 1, 4'b0001, 7'h06, 0);
    chk("flt_valid", 32'(bus.value_valid), 32'd1);
    chk("flt_value", 32'(bus.value_out),   32'h3211);
`endif

    // Randomized traffic against the model
    tick(1, 0, 4'h0, 7'h00, 0);
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] sel;
      logic [6:0] seg;
      bit         r;
      bit         s;
      bit         a;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 70);
      a = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 88) sel = 4'(1 << $urandom_range(0, 3));
      else                            sel = 4'($urandom);
      if ($urandom_range(0, 99) < 85) seg = codes[$urandom_range(0, 3)];
      else if ($urandom_range(0, 1) == 1) seg = codes[$urandom_range(0, 15)];
      else                            seg = 7'($urandom);
      tick(r, s, sel, seg, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
